// File: rtl/dcache_tag_arbiter_if.sv
// Bundle of all request/response and tag-array signals around dcache_tag_arbiter.
// slave is the arbiter side; master is the requesters plus the tag array.
interface dcache_tag_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 38,
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned WAY_NUM    = 4
) ();
    logic                  init_done;

    logic                  ld_req_valid;
    logic [ADDR_WIDTH-1:0] ld_req_idx;
    logic [WAY_NUM-1:0]    ld_req_way;
    logic                  ld_req_ready;
    logic                  ld_resp_valid;
    logic [DATA_WIDTH-1:0] ld_resp_data;

    logic                  st_req_valid;
    logic [ADDR_WIDTH-1:0] st_req_idx;
    logic [WAY_NUM-1:0]    st_req_way;
    logic                  st_req_ready;
    logic                  st_resp_valid;
    logic [DATA_WIDTH-1:0] st_resp_data;

    logic                  rf_req_valid;
    logic [ADDR_WIDTH-1:0] rf_req_idx;
    logic [WAY_NUM-1:0]    rf_req_way;
    logic [DATA_WIDTH-1:0] rf_req_data;
    logic                  rf_req_ready;

    logic                  tag_rd_en;
    logic [WAY_NUM-1:0]    tag_rd_way;
    logic [ADDR_WIDTH-1:0] tag_rd_idx;
    logic [DATA_WIDTH-1:0] tag_rd_data;
    logic                  tag_wr_en;
    logic [WAY_NUM-1:0]    tag_wr_way;
    logic [ADDR_WIDTH-1:0] tag_wr_idx;
    logic [DATA_WIDTH-1:0] tag_wr_data;

    modport slave (
        output init_done,
        input  ld_req_valid, ld_req_idx, ld_req_way,
        output ld_req_ready, ld_resp_valid, ld_resp_data,
        input  st_req_valid, st_req_idx, st_req_way,
        output st_req_ready, st_resp_valid, st_resp_data,
        input  rf_req_valid, rf_req_idx, rf_req_way, rf_req_data,
        output rf_req_ready,
        output tag_rd_en, tag_rd_way, tag_rd_idx,
        input  tag_rd_data,
        output tag_wr_en, tag_wr_way, tag_wr_idx, tag_wr_data
    );

    modport master (
        input  init_done,
        output ld_req_valid, ld_req_idx, ld_req_way,
        input  ld_req_ready, ld_resp_valid, ld_resp_data,
        output st_req_valid, st_req_idx, st_req_way,
        input  st_req_ready, st_resp_valid, st_resp_data,
        output rf_req_valid, rf_req_idx, rf_req_way, rf_req_data,
        input  rf_req_ready,
        input  tag_rd_en, tag_rd_way, tag_rd_idx,
        output tag_rd_data,
        input  tag_wr_en, tag_wr_way, tag_wr_idx, tag_wr_data
    );
endinterface

// File: rtl/dcache_tag_arbiter.sv
// Single-port dcache tag-array scheduler: post-reset invalidation sweep, then
// per-cycle arbitration of refill writes, store reads and load reads.
module dcache_tag_arbiter #(
    parameter int unsigned DATA_WIDTH   = 38,
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned WAY_NUM      = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                clock,
    input logic                reset,
    dcache_tag_arbiter_if.slave bus
);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {StInit, StRun} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] sweep_q;
    logic [SW-1:0]         starve_q;
    logic                  rd_issued_q;
    logic                  owner_st_q;

    logic run, init, st_prio, st_hi, rf_gnt, ld_gnt, st_gnt, rd_gnt;

    // Gating with reset keeps every output quiet while reset is held.
    assign run     = (state_q == StRun) && !reset;
    assign init    = (state_q == StInit) && !reset;
    assign st_prio = starve_q >= SW'(STARVE_LIMIT);
    assign rf_gnt  = run && bus.rf_req_valid;
    assign st_hi   = run && !bus.rf_req_valid && bus.st_req_valid && st_prio;
    assign ld_gnt  = run && !bus.rf_req_valid && !st_hi && bus.ld_req_valid;
    assign st_gnt  = st_hi || (run && !bus.rf_req_valid && !bus.ld_req_valid && bus.st_req_valid);
    assign rd_gnt  = ld_gnt || st_gnt;

    always_comb begin
        bus.init_done    = (state_q == StRun) && !reset;
        bus.rf_req_ready = rf_gnt;
        bus.ld_req_ready = ld_gnt;
        bus.st_req_ready = st_gnt;

        bus.tag_wr_en   = init || rf_gnt;
        bus.tag_wr_way  = init ? {WAY_NUM{1'b1}} : bus.rf_req_way;
        bus.tag_wr_idx  = init ? sweep_q : bus.rf_req_idx;
        bus.tag_wr_data = init ? {DATA_WIDTH{1'b0}} : bus.rf_req_data;

        bus.tag_rd_en  = rd_gnt;
        bus.tag_rd_idx = st_gnt ? bus.st_req_idx : bus.ld_req_idx;
        bus.tag_rd_way = st_gnt ? bus.st_req_way : bus.ld_req_way;

        bus.ld_resp_valid = rd_issued_q && !owner_st_q && !reset;
        bus.st_resp_valid = rd_issued_q && owner_st_q && !reset;
        bus.ld_resp_data  = bus.tag_rd_data;
        bus.st_resp_data  = bus.tag_rd_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StInit;
            sweep_q     <= '0;
            starve_q    <= '0;
            rd_issued_q <= 1'b0;
            owner_st_q  <= 1'b0;
        end else begin
            case (state_q)
                StInit: begin
                    sweep_q <= sweep_q + 1'b1;
                    if (sweep_q == {ADDR_WIDTH{1'b1}}) state_q <= StRun;
                end
                default: state_q <= StRun;
            endcase

            rd_issued_q <= rd_gnt;
            owner_st_q  <= st_gnt;

            if (st_gnt) begin
                starve_q <= '0;
            end else if (bus.st_req_valid && !st_prio) begin
                starve_q <= starve_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dcache_tag_arbiter.sv
// Directed bench for dcache_tag_arbiter: a reference model predicts grants and
// tag-port activity each cycle; read responses are checked via a scoreboard queue.
module tb_dcache_tag_arbiter;
    localparam int unsigned DW = 38;
    localparam int unsigned AW = 9;
    localparam int unsigned WN = 4;
    localparam int unsigned SL = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    dcache_tag_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAY_NUM(WN)) bus ();

    dcache_tag_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAY_NUM(WN), .STARVE_LIMIT(SL)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic          is_st;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    bit   m_run      = 1'b0;
    int   m_cnt      = 0;
    int   m_starve   = 0;
    bit   g_rf, g_ld, g_st;

    function automatic logic [DW-1:0] rnd_data();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already driven; predict, check at negedge, update model.
    task automatic cycle();
        bit   run_e, rf_g, st_hi, ld_g, st_g, have_rsp, sweep_e;
        rsp_t r, nr;
        run_e = m_run && !reset;
        rf_g  = run_e && bus.rf_req_valid;
        st_hi = run_e && !bus.rf_req_valid && bus.st_req_valid && (m_starve >= SL);
        ld_g  = run_e && !bus.rf_req_valid && !st_hi && bus.ld_req_valid;
        st_g  = st_hi || (run_e && !bus.rf_req_valid && !bus.ld_req_valid && bus.st_req_valid);
        sweep_e = !m_run && !reset;
        have_rsp = 1'b0;
        r = '0;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            have_rsp = 1'b1;
            bus.tag_rd_data = r.data;
        end else begin
            bus.tag_rd_data = rnd_data();
        end

        @(negedge clock);
        chk("init_done", bus.init_done, run_e);
        chk("rf_ready", bus.rf_req_ready, rf_g);
        chk("ld_ready", bus.ld_req_ready, ld_g);
        chk("st_ready", bus.st_req_ready, st_g);
        chk("wr_en", bus.tag_wr_en, sweep_e || rf_g);
        chk("rd_en", bus.tag_rd_en, ld_g || st_g);
        if (sweep_e) begin
            chk("sweep_idx", bus.tag_wr_idx, m_cnt);
            chk("sweep_way", bus.tag_wr_way, {WN{1'b1}});
            chk("sweep_data", bus.tag_wr_data, 0);
        end else if (rf_g) begin
            chk("rf_wr_idx", bus.tag_wr_idx, bus.rf_req_idx);
            chk("rf_wr_way", bus.tag_wr_way, bus.rf_req_way);
            chk("rf_wr_data", bus.tag_wr_data, bus.rf_req_data);
        end
        if (ld_g) begin
            chk("ld_rd_idx", bus.tag_rd_idx, bus.ld_req_idx);
            chk("ld_rd_way", bus.tag_rd_way, bus.ld_req_way);
        end else if (st_g) begin
            chk("st_rd_idx", bus.tag_rd_idx, bus.st_req_idx);
            chk("st_rd_way", bus.tag_rd_way, bus.st_req_way);
        end
        chk("ld_resp_valid", bus.ld_resp_valid, have_rsp && !r.is_st && !reset);
        chk("st_resp_valid", bus.st_resp_valid, have_rsp && r.is_st && !reset);
        if (have_rsp && !reset) begin
            if (r.is_st) chk("st_resp_data", bus.st_resp_data, r.data);
            else         chk("ld_resp_data", bus.ld_resp_data, r.data);
        end

        if (reset) begin
            m_run = 1'b0;
            m_cnt = 0;
            m_starve = 0;
            sb.delete();
        end else begin
            if (!m_run) begin
                if (m_cnt == (1 << AW) - 1) m_run = 1'b1;
                m_cnt++;
            end
            if (st_g) m_starve = 0;
            else if (bus.st_req_valid && m_starve < SL) m_starve++;
            if (ld_g || st_g) begin
                nr.is_st = st_g;
                nr.data  = rnd_data();
                sb.push_back(nr);
            end
        end
        g_rf = rf_g;
        g_ld = ld_g;
        g_st = st_g;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int st_wins;
        int ld_wins;
        reset = 1'b1;
        bus.ld_req_valid = 1'b0; bus.ld_req_idx = '0; bus.ld_req_way = 4'b0001;
        bus.st_req_valid = 1'b0; bus.st_req_idx = '0; bus.st_req_way = 4'b0010;
        bus.rf_req_valid = 1'b0; bus.rf_req_idx = '0; bus.rf_req_way = 4'b0100;
        bus.rf_req_data  = '0;
        bus.tag_rd_data  = '0;

        // Reset, then a full invalidation sweep.
        repeat (2) cycle();
        reset = 1'b0;
        repeat (1 << AW) cycle();
        cycle();

        // Refill, load and store all requesting; then load/store contend.
        bus.rf_req_valid = 1'b1;
        bus.rf_req_idx = 9'd77; bus.rf_req_way = 4'b1000; bus.rf_req_data = rnd_data();
        bus.ld_req_valid = 1'b1; bus.ld_req_idx = 9'd10;
        bus.st_req_valid = 1'b1; bus.st_req_idx = 9'd20;
        cycle();
        if (g_rf) bus.rf_req_valid = 1'b0;
        st_wins = 0;
        ld_wins = 0;
        repeat (15) begin
            cycle();
            if (g_ld) begin bus.ld_req_idx = 9'($urandom); ld_wins++; end
            if (g_st) begin bus.st_req_idx = 9'($urandom); st_wins++; end
        end
        chk("st_win_count", st_wins, 3);
        chk("ld_win_count", ld_wins, 12);
        bus.ld_req_valid = 1'b0;
        bus.st_req_valid = 1'b0;
        cycle();

        // Back-to-back loads to idx 5, 6, 7.
        bus.ld_req_valid = 1'b1;
        for (int i = 5; i < 8; i++) begin
            bus.ld_req_idx = 9'(i);
            bus.ld_req_way = (i == 7) ? 4'b1111 : 4'(1 << (i - 5));
            cycle();
        end
        bus.ld_req_valid = 1'b0;
        repeat (2) cycle();

        // Lone store read.
        bus.st_req_valid = 1'b1; bus.st_req_idx = 9'd300; bus.st_req_way = 4'b1000;
        cycle();
        bus.st_req_valid = 1'b0;
        repeat (2) cycle();

        // Reset at sweep index 200 restarts the sweep from 0.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (200) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (1 << AW) cycle();
        cycle();

        // Reset the cycle after a load grant drops the pending response.
        bus.ld_req_valid = 1'b1; bus.ld_req_idx = 9'd42; bus.ld_req_way = 4'b0001;
        cycle();
        bus.ld_req_valid = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (3) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dcache_tag_arbiter.md
# dcache_tag_arbiter

Single-port access scheduler for the dcache tag array. It shares one tag-SRAM port among four users: the post-reset invalidation sweep, refill tag writes, load-pipeline tag reads and store-pipeline tag reads. Each cycle it issues at most one read or one write to the tag array and returns read data to the granted requester one cycle later. It sits between the dcache pipelines/refill unit and the tag array.

## Interface
Parameters:
- DATA_WIDTH, 38, tag entry width (tag + state bits)
- ADDR_WIDTH, 9, set index width (512 sets)
- WAY_NUM, 4, number of ways; width of one-hot way vectors
- STARVE_LIMIT, 4, consecutive store-read losses before store read outranks load read

Ports:
- clock  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- init_done  output  1  high once the invalidation sweep completes
- ld_req_valid  input  1  load tag-read request
- ld_req_idx  input  ADDR_WIDTH  load set index
- ld_req_way  input  WAY_NUM  load way select, one-hot or all-ones
- ld_req_ready  output  1  load request granted this cycle
- ld_resp_valid  output  1  load read data valid
- ld_resp_data  output  DATA_WIDTH  load read data
- st_req_valid, st_req_idx, st_req_way, st_req_ready, st_resp_valid, st_resp_data  same as the ld_* ports, for the store pipeline
- rf_req_valid  input  1  refill tag-write request
- rf_req_idx  input  ADDR_WIDTH  refill set index
- rf_req_way  input  WAY_NUM  refill way, one-hot
- rf_req_data  input  DATA_WIDTH  tag entry to write
- rf_req_ready  output  1  refill write accepted this cycle
- tag_rd_en  output  1  tag array read enable
- tag_rd_way  output  WAY_NUM  tag array read way
- tag_rd_idx  output  ADDR_WIDTH  tag array read index
- tag_rd_data  input  DATA_WIDTH  tag array read data, valid one cycle after tag_rd_en
- tag_wr_en  output  1  tag array write enable
- tag_wr_way  output  WAY_NUM  tag array write way
- tag_wr_idx  output  ADDR_WIDTH  tag array write index
- tag_wr_data  output  DATA_WIDTH  tag array write data

## Operation
- FSM states: INIT, RUN.
- Reset entry: reset forces INIT, sweep counter = 0, starvation counter = 0, and all resp_valid = 0.
- INIT: each cycle drives tag_wr_en=1, tag_wr_way=all-ones, tag_wr_idx=counter and tag_wr_data=0, then increments the counter. All *_req_ready are 0.
  - When the counter reaches 2^ADDR_WIDTH-1, the write for that index is issued and the FSM moves to RUN.
  - init_done=1 from the next cycle onward.
- RUN: the arbiter grants exactly one request per cycle, in this priority order:
  - refill write;
  - then store read if starve_cnt ≥ STARVE_LIMIT;
  - then load read;
  - then store read.
- Grant is combinational: ready=valid&&granted. The requester drops or changes its request only after a cycle with valid&&ready.
- Write grant: tag_wr_* is driven from rf_req_*, and tag_rd_en=0.
- Read grant: tag_rd_en=1 and tag_rd_idx/way are driven from the winner. tag_wr_en=0 and tag_rd_en=0 whenever those ports are not granted.
- Never assert tag_rd_en and tag_wr_en in the same cycle.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) when st_req_valid is high and not granted.
  - Resets to 0 on a store grant.
  - Holds when st_req_valid is low.
- Response routing: a one-bit registered owner tag (LD/ST) plus a registered read-issued flag. In the cycle after a read grant, the owner's resp_valid=1 and its resp_data=tag_rd_data. The other resp_valid is 0.
- resp_data is pure passthrough of tag_rd_data for both ports. It is don't-care when resp_valid=0.
- Reset asserted mid-sweep or mid-RUN restarts the sweep from index 0. Any read response pending at that moment is dropped (resp_valid=0 in the cycle after reset).

## Timing
- Reset values:
  - init_done=0
  - all *_req_ready=0
  - ld_resp_valid=st_resp_valid=0
  - tag_rd_en=0
  - tag_wr_en=0 while reset is held; the sweep begins the first cycle after reset deasserts.
- Sweep length: exactly 2^ADDR_WIDTH write cycles (512 by default). init_done rises in cycle 2^ADDR_WIDTH after reset release.
- Read latency: grant in cycle N, resp_valid in cycle N+1. The block sustains one read per cycle back-to-back.
- Refill write: accepted and issued in the same cycle (zero added latency).
- A read of an index written in the previous cycle returns whatever the tag array returns. The arbiter performs no bypass.

## Test plan
- Reset then idle: sweep issues tag_wr_idx 0..511 with way=4'b1111 and data=0, one per cycle. init_done rises in cycle 512. No ready is asserted during the sweep.
- Simultaneous rf, ld and st valid in RUN: rf_req_ready=1 and tag_wr_en=1 with the refill idx/way/data. The next cycle grants ld. Nothing is granted to st until the starvation counter reaches the limit.
- Continuous ld and st valid, no refill: ld wins 4 cycles, st wins on the 5th, and the pattern repeats. st_resp_valid appears exactly one cycle after each st grant, carrying tag_rd_data.
- Back-to-back loads to idx 5, 6, 7: tag_rd_en held for 3 cycles. ld_resp_valid high for the following 3 cycles with the matching data; st_resp_valid stays 0.
- Reset asserted at sweep index 200: the next sweep write after release is idx 0, and init_done stays 0 until 512 cycles later.
- Reset asserted the cycle after a load grant: ld_resp_valid=0 in the following cycle and the FSM is back in INIT.
